// File: rtl/hdc_frame_packer_if.sv
// hdc_frame_packer_if: sample-beat input stream and packed-frame output stream of the frame packer
interface hdc_frame_packer_if #(
  parameter int CHANNEL_WIDTH  = 16,
  parameter int INPUT_CHANNELS = 4,
  parameter int MODE_WIDTH     = 2,
  parameter int LABEL_WIDTH    = 4
);
  logic sample_valid, sample_ready, sample_last, frame_valid, frame_ready;
  logic [CHANNEL_WIDTH-1:0] sample;
  logic [MODE_WIDTH-1:0] mode_in, mode_out;
  logic [LABEL_WIDTH-1:0] label_in, label_out;
  logic [CHANNEL_WIDTH*INPUT_CHANNELS-1:0] frame;
  modport master(output sample_valid, sample, sample_last, mode_in, label_in, frame_ready,
                 input sample_ready, frame_valid, frame, mode_out, label_out);
  modport slave(input sample_valid, sample, sample_last, mode_in, label_in, frame_ready,
                output sample_ready, frame_valid, frame, mode_out, label_out);
endinterface

// File: rtl/hdc_frame_packer.sv
// hdc_frame_packer: packs per-channel sample beats into frames, drops malformed frames.
// Define HDC_PACKER_ERRCNT_EN to add the saturating dropped-frame counter err_count.
module hdc_frame_packer #(
  parameter int CHANNEL_WIDTH  = 16,
  parameter int INPUT_CHANNELS = 4,
  parameter int MODE_WIDTH     = 2,
  parameter int LABEL_WIDTH    = 4
) (
  input logic clk,
  input logic rst,
  hdc_frame_packer_if.slave bus
`ifdef HDC_PACKER_ERRCNT_EN
  , output logic [15:0] err_count
`endif
);
  localparam int FW = CHANNEL_WIDTH * INPUT_CHANNELS;
  localparam int CNTW = INPUT_CHANNELS > 1 ? $clog2(INPUT_CHANNELS) : 1;
  typedef enum logic [1:0] {FILL, HOLD, DROP} state_t;
  state_t state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [FW-1:0] fill, fill_n;
  logic [MODE_WIDTH-1:0] fill_mode, mode_n;
  logic [LABEL_WIDTH-1:0] fill_label, label_n;
  logic accept, last_ch, good, bad, out_free, load;
  assign bus.sample_ready = state != HOLD;
  always_comb begin
    accept = bus.sample_valid && state != HOLD;
    last_ch = cnt == CNTW'(INPUT_CHANNELS - 1);
    out_free = !bus.frame_valid || bus.frame_ready;
    good = state == FILL && accept && last_ch && bus.sample_last;
    bad = state == FILL && accept && (last_ch != bus.sample_last);
    load = (good || state == HOLD) && out_free;
    fill_n = fill;
    fill_n[(INPUT_CHANNELS - 1 - int'(cnt)) * CHANNEL_WIDTH +: CHANNEL_WIDTH] = bus.sample;
    mode_n = cnt == '0 ? bus.mode_in : fill_mode;
    label_n = cnt == '0 ? bus.label_in : fill_label;
    cnt_n = state == FILL && accept ? (last_ch || bus.sample_last ? '0 : cnt + 1'b1) : cnt;
    state_n = state;
    case (state)
      FILL: if (good && !out_free) state_n = HOLD;
            else if (bad && !bus.sample_last) state_n = DROP;
      HOLD: if (out_free) state_n = FILL;
      DROP: if (accept && bus.sample_last) state_n = FILL;
      default: state_n = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // fill buffer holds the frame being packed (or the complete one parked in HOLD)
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
      fill_mode <= '0;
      fill_label <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame <= '0;
      bus.mode_out <= '0;
      bus.label_out <= '0;
    end else begin
      if (state == FILL && accept) begin
        fill <= fill_n;
        fill_mode <= mode_n;
        fill_label <= label_n;
      end
      if (load) begin
        bus.frame_valid <= 1'b1;
        bus.frame <= state == HOLD ? fill : fill_n;
        bus.mode_out <= state == HOLD ? fill_mode : mode_n;
        bus.label_out <= state == HOLD ? fill_label : label_n;
      end else if (bus.frame_ready) bus.frame_valid <= 1'b0;
    end
  end
`ifdef HDC_PACKER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (bad && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
  end
`endif
endmodule
